// File: rtl/ex_result_buffer.sv
// ex_result_buffer: execute-stage result FIFO with valid/ready writeback port
// and youngest-writer forwarding tap for hazard resolution.
module ex_result_buffer #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [DATA_W-1:0]          ex_result,
    input  logic [RD_W-1:0]            ex_rd,
    input  logic                       ex_we,
    input  logic [3:0]                 ex_op,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [DATA_W-1:0]          wb_result,
    output logic [RD_W-1:0]            wb_rd,
    output logic                       wb_we,
    output logic [3:0]                 wb_op,
    output logic                       wb_zero,
    output logic                       fwd_valid,
    output logic [RD_W-1:0]            fwd_rd,
    output logic [DATA_W-1:0]          fwd_result,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] res_q [DEPTH];
    logic [RD_W-1:0]   rd_q  [DEPTH];
    logic [3:0]        op_q  [DEPTH];
    logic [DEPTH-1:0]  vld_q, we_q, zero_q;
    logic [PW-1:0]     wr_ptr, rd_ptr, idx;
    logic [CW-1:0]     count;
    logic              push, pop;

    assign ex_ready  = count != CW'(DEPTH);
    assign wb_valid  = count != '0;
    assign push      = ex_valid & ex_ready;
    assign pop       = wb_valid & wb_ready;
    assign occupancy = count;

    assign wb_result = wb_valid ? res_q[rd_ptr]  : '0;
    assign wb_rd     = wb_valid ? rd_q[rd_ptr]   : '0;
    assign wb_we     = wb_valid & we_q[rd_ptr];
    assign wb_op     = wb_valid ? op_q[rd_ptr]   : '0;
    assign wb_zero   = wb_valid & zero_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
            we_q   <= '0;
            zero_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
                op_q[i]  <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
        end else begin
            if (push) begin
                res_q[wr_ptr]  <= ex_result;
                rd_q[wr_ptr]   <= ex_rd;
                op_q[wr_ptr]   <= ex_op;
                we_q[wr_ptr]   <= ex_we & (ex_rd != '0);
                zero_q[wr_ptr] <= ex_result == '0;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Walk oldest to youngest so the youngest writing entry wins.
    always_comb begin
        fwd_valid  = 1'b0;
        fwd_rd     = '0;
        fwd_result = '0;
        idx        = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wr_ptr - PW'(i);
            if (vld_q[idx] & we_q[idx]) begin
                fwd_valid  = 1'b1;
                fwd_rd     = rd_q[idx];
                fwd_result = res_q[idx];
            end
        end
    end
endmodule
